// File: rtl/data_bus_lsu.sv
// Load/store unit: turns one MEM-stage access into one external data-bus cycle,
// extends load data, flags misaligned accesses and aborts hung bus cycles.
module data_bus_lsu #(
    parameter int          BIT_WIDTH = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_valid,
    input  logic                 mem_write,
    input  logic [2:0]           mem_funct3,
    input  logic [BIT_WIDTH-1:0] mem_addr,
    input  logic [BIT_WIDTH-1:0] mem_wdata,
    input  logic                 mem_flush,
    output logic                 lsu_stall,
    output logic                 load_valid,
    output logic [BIT_WIDTH-1:0] load_data,
    output logic                 misalign,
    output logic                 bus_err,
    output logic [BIT_WIDTH-1:0] badaddr,
    output logic [BIT_WIDTH-1:0] DAD,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n,
    inout  wire  [BIT_WIDTH-1:0] DDT
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [1:0] SZ_W = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_B = 2'b10;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

    // Undefined funct3 encodings (011, 110, 111) fall through to word.
    function automatic logic [1:0] size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   size_of = SZ_B;
            2'b01:   size_of = SZ_H;
            default: size_of = SZ_W;
        endcase
    endfunction

    function automatic logic is_aligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_W:    is_aligned = (a == 2'b00);
            SZ_H:    is_aligned = !a[0];
            default: is_aligned = 1'b1;
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] store_lane(input logic [BIT_WIDTH-1:0] d,
                                                        input logic [1:0] sz);
        case (sz)
            SZ_B:    store_lane = {{(BIT_WIDTH-8){1'b0}}, d[7:0]};
            SZ_H:    store_lane = {{(BIT_WIDTH-16){1'b0}}, d[15:0]};
            default: store_lane = d;
        endcase
    endfunction

    function automatic logic [BIT_WIDTH-1:0] extend(input logic [BIT_WIDTH-1:0] d,
                                                    input logic [1:0] sz,
                                                    input logic uns);
        case (sz)
            SZ_B:    extend = {{(BIT_WIDTH-8){d[7] & !uns}}, d[7:0]};
            SZ_H:    extend = {{(BIT_WIDTH-16){d[15] & !uns}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 flushed;
    logic                 uns_p1;
    logic [BIT_WIDTH-1:0] lane_p1;

    logic [1:0] req_size;
    logic       req_aligned;
    logic       accept;
    logic       ack;
    logic       timeout_hit;

    assign req_size    = size_of(mem_funct3);
    assign req_aligned = is_aligned(req_size, mem_addr[1:0]);
    assign accept      = (state == IDLE) && mem_valid && !mem_flush && req_aligned;
    assign ack         = (state == BUS) && !ACKD_n;
    assign timeout_hit = (state == BUS) && ACKD_n && (TIMEOUT != 0) && ((cnt + 1'b1) == TO_LIMIT);

    assign lsu_stall = mem_valid && !mem_flush && req_aligned && (state != DONE);
    assign DDT       = (MREQ && WRITE) ? lane_p1 : {BIT_WIDTH{1'bz}};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUS;
            BUS:     if (ack || timeout_hit) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Accept stage: capture the request and drive the bus from the next cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MREQ       <= 1'b0;
            WRITE      <= 1'b0;
            SIZE       <= SZ_W;
            DAD        <= '0;
            load_valid <= 1'b0;
            load_data  <= '0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            badaddr    <= '0;
            cnt        <= '0;
            flushed    <= 1'b0;
        end else begin
            load_valid <= 1'b0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
            if (accept) begin
                MREQ    <= 1'b1;
                WRITE   <= mem_write;
                SIZE    <= req_size;
                DAD     <= mem_addr;
                cnt     <= '0;
                flushed <= 1'b0;
            end else if (state == IDLE && mem_valid && !req_aligned) begin
                misalign <= 1'b1;
                badaddr  <= mem_addr;
            end
            // Bus stage: wait for acknowledge or give up after the timeout
            if (state == BUS) begin
                if (mem_flush) flushed <= 1'b1;
                if (ack) begin
                    MREQ       <= 1'b0;
                    load_valid <= !WRITE && !flushed && !mem_flush;
                    if (!WRITE) load_data <= extend(DDT, SIZE, uns_p1);
                end else if (timeout_hit) begin
                    MREQ    <= 1'b0;
                    bus_err <= 1'b1;
                    badaddr <= DAD;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lane_p1 <= store_lane(mem_wdata, req_size);
            uns_p1  <= mem_funct3[2];
        end
    end

endmodule

// File: tb/tb_data_bus_lsu.sv
// Scoreboard bench for data_bus_lsu: directed accesses push expected results,
// a negedge monitor pops and compares load_valid / misalign / bus_err events.
module tb_data_bus_lsu;

    localparam int TB_TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  mem_funct3 = 3'b010;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_flush = 1'b0;
    logic        lsu_stall, load_valid, misalign, bus_err, MREQ, WRITE;
    logic [31:0] load_data, badaddr, DAD;
    logic [1:0]  SIZE;
    logic        ACKD_n = 1'b1;
    wire  [31:0] DDT;
    logic [31:0] ddt_drv = '0;
    logic        ddt_oe = 1'b0;

    assign DDT = ddt_oe ? ddt_drv : 32'hzzzz_zzzz;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_load[$];
    logic [31:0] exp_mis[$];
    logic [31:0] exp_err[$];

    data_bus_lsu #(.BIT_WIDTH(32), .TIMEOUT(TB_TO)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_write(mem_write),
        .mem_funct3(mem_funct3), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_flush(mem_flush), .lsu_stall(lsu_stall), .load_valid(load_valid),
        .load_data(load_data), .misalign(misalign), .bus_err(bus_err),
        .badaddr(badaddr), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
        .ACKD_n(ACKD_n), .DDT(DDT)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (load_valid) begin
                if (exp_load.size() == 0) chk("unexpected_load_valid", load_data, 32'hxxxx_xxxx);
                else chk("load_data", load_data, exp_load.pop_front());
            end
            if (misalign) begin
                if (exp_mis.size() == 0) chk("unexpected_misalign", badaddr, 32'hxxxx_xxxx);
                else chk("misalign_badaddr", badaddr, exp_mis.pop_front());
            end
            if (bus_err) begin
                if (exp_err.size() == 0) chk("unexpected_bus_err", badaddr, 32'hxxxx_xxxx);
                else chk("bus_err_badaddr", badaddr, exp_err.pop_front());
            end
        end
    end

    // ack_cyc: BUS cycle in which ACKD_n is low (0 = never, expect timeout)
    task automatic access(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic [31:0] exp_data, input logic [1:0] exp_size,
                          input int ack_cyc, input logic flush);
        int n;
        n = (ack_cyc == 0) ? TB_TO : ack_cyc;
        if (ack_cyc == 0) exp_err.push_back(addr);
        else if (!wr && !flush) exp_load.push_back(exp_data);
        @(posedge clk) #1;
        mem_valid = 1'b1; mem_write = wr; mem_funct3 = f3; mem_addr = addr; mem_wdata = wdata;
        @(negedge clk);
        chk("stall_accept", {31'b0, lsu_stall}, 32'd1);
        chk("mreq_accept", {31'b0, MREQ}, 32'd0);
        for (int c = 1; c <= n; c++) begin
            @(posedge clk) #1;
            if (flush && c == 1) mem_flush = 1'b1;
            if (c == ack_cyc) begin
                ACKD_n = 1'b0;
                if (!wr) begin ddt_drv = rdata; ddt_oe = 1'b1; end
            end
            @(negedge clk);
            chk("mreq_bus", {31'b0, MREQ}, 32'd1);
            chk("dad_bus", DAD, addr);
            chk("write_bus", {31'b0, WRITE}, {31'b0, wr});
            chk("size_bus", {30'b0, SIZE}, {30'b0, exp_size});
            chk("stall_bus", {31'b0, lsu_stall}, {31'b0, !flush});
            if (wr) chk("ddt_store", DDT, exp_data);
        end
        @(posedge clk) #1;
        ACKD_n = 1'b1; ddt_oe = 1'b0;
        if (wr) begin ddt_drv = 32'h5A5A_C3C3; ddt_oe = 1'b1; end
        @(negedge clk);
        chk("mreq_done", {31'b0, MREQ}, 32'd0);
        chk("stall_done", {31'b0, lsu_stall}, 32'd0);
        if (wr) chk("ddt_released", DDT, 32'h5A5A_C3C3);
        @(posedge clk) #1;
        ddt_oe = 1'b0; mem_valid = 1'b0; mem_flush = 1'b0; mem_write = 1'b0;
    endtask

    task automatic misaligned(input logic [2:0] f3, input logic [31:0] addr);
        exp_mis.push_back(addr);
        @(posedge clk) #1;
        mem_valid = 1'b1; mem_write = 1'b0; mem_funct3 = f3; mem_addr = addr;
        @(negedge clk);
        chk("stall_misalign", {31'b0, lsu_stall}, 32'd0);
        @(posedge clk) #1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("mreq_misalign", {31'b0, MREQ}, 32'd0);
        chk("stall_misalign_after", {31'b0, lsu_stall}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_mreq", {31'b0, MREQ}, 32'd0);
        chk("rst_write", {31'b0, WRITE}, 32'd0);
        chk("rst_size", {30'b0, SIZE}, 32'd0);
        chk("rst_dad", DAD, 32'd0);
        chk("rst_load_valid", {31'b0, load_valid}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_badaddr", badaddr, 32'd0);
        chk("rst_errs", {30'b0, misalign, bus_err}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        //     wr    f3      addr          wdata         rdata         expected      size   ack flush
        access(1'b0, 3'b010, 32'h0800_0010, 32'h0,        32'h1234_5678, 32'h1234_5678, 2'b00, 1, 1'b0);
        access(1'b0, 3'b000, 32'h0800_0003, 32'h0,        32'h0000_0080, 32'hFFFF_FF80, 2'b10, 1, 1'b0);
        access(1'b0, 3'b100, 32'h0800_0003, 32'h0,        32'h0000_0080, 32'h0000_0080, 2'b10, 1, 1'b0);
        access(1'b0, 3'b001, 32'h0800_0002, 32'h0,        32'h0000_8001, 32'hFFFF_8001, 2'b01, 1, 1'b0);
        access(1'b0, 3'b101, 32'h0800_0002, 32'h0,        32'h0000_8001, 32'h0000_8001, 2'b01, 1, 1'b0);
        access(1'b0, 3'b011, 32'h0800_0008, 32'h0,        32'h8765_4321, 32'h8765_4321, 2'b00, 1, 1'b0);
        access(1'b1, 3'b001, 32'h0800_0006, 32'hDEAD_BEEF, 32'h0,        32'h0000_BEEF, 2'b01, 1, 1'b0);
        access(1'b1, 3'b000, 32'h0800_0001, 32'hCAFE_BA5E, 32'h0,        32'h0000_005E, 2'b10, 1, 1'b0);
        access(1'b1, 3'b010, 32'h0800_000C, 32'h0BAD_F00D, 32'h0,        32'h0BAD_F00D, 2'b00, 1, 1'b0);
        misaligned(3'b010, 32'h0800_0002);
        misaligned(3'b001, 32'h0800_0001);
        access(1'b0, 3'b010, 32'h0800_0040, 32'h0,        32'h0,         32'h0,         2'b00, 0, 1'b0);
        access(1'b0, 3'b010, 32'h0800_0044, 32'h0,        32'hA5A5_0F0F, 32'hA5A5_0F0F, 2'b00, 3, 1'b0);
        access(1'b0, 3'b010, 32'h0800_0048, 32'h0,        32'h7777_7777, 32'h7777_7777, 2'b00, 1, 1'b1);

        // Asynchronous reset in the middle of a store bus cycle
        @(posedge clk) #1;
        mem_valid = 1'b1; mem_write = 1'b1; mem_funct3 = 3'b010;
        mem_addr = 32'h0800_0020; mem_wdata = 32'h1111_2222;
        @(posedge clk) #1;
        @(negedge clk);
        chk("mreq_pre_reset", {31'b0, MREQ}, 32'd1);
        chk("ddt_pre_reset", DDT, 32'h1111_2222);
        #2 rst = 1'b0;
        #1 chk("mreq_async_reset", {31'b0, MREQ}, 32'd0);
        chk("dad_async_reset", DAD, 32'd0);
        ddt_drv = 32'h3C3C_9696; ddt_oe = 1'b1;
        #1 chk("ddt_async_reset", DDT, 32'h3C3C_9696);
        ddt_oe = 1'b0; mem_valid = 1'b0; mem_write = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        access(1'b0, 3'b010, 32'h0800_0030, 32'h0,        32'h0F1E_2D3C, 32'h0F1E_2D3C, 2'b00, 1, 1'b0);

        repeat (3) @(negedge clk);
        chk("load_queue_empty", exp_load.size(), 32'd0);
        chk("misalign_queue_empty", exp_mis.size(), 32'd0);
        chk("bus_err_queue_empty", exp_err.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
